// File: rtl/uob_output_arbiter.sv
// uob_output_arbiter: round-robin drain of N_UNITS unit output buffers onto
// one result bus. Grants a unit with a single-cycle rd_en, checks the header
// word of the fixed-length burst that follows, then forwards the data words
// with pkt_start/pkt_end framing and the source unit id.
module uob_output_arbiter #(
  parameter int N_UNITS     = 4,
  parameter int UNIT_ID_MSB = (N_UNITS > 1) ? $clog2(N_UNITS) - 1 : 0,
  parameter int OUT_WIDTH   = 8,
  parameter int OUT_N_WORDS = 40
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_UNITS-1:0]             unit_empty,
  input  logic [N_UNITS*OUT_WIDTH-1:0]   unit_dout,
  output logic [N_UNITS-1:0]             unit_rd_en,
  input  logic                           dst_ready,
  output logic [OUT_WIDTH-1:0]           dout,
  output logic                           dout_valid,
  output logic                           pkt_start,
  output logic                           pkt_end,
  output logic [UNIT_ID_MSB:0]           unit_id,
  output logic                           busy,
  output logic                           hdr_err
);

  localparam int ID_W  = UNIT_ID_MSB + 1;
  localparam int CNT_W = $clog2(OUT_N_WORDS + 1);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    HDR,
    XFER,
    GAP
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     pick_id;
  logic [ID_W-1:0]     cand_id;
  logic                pick_found;
  logic [CNT_W-1:0]    cnt;
  logic                drop;
  logic                last_word;
  logic [OUT_WIDTH-1:0] cur_word;

  assign last_word = (cnt == CNT_W'(OUT_N_WORDS - 1));
  assign busy      = (state != IDLE);

  // Round-robin pick: first non-empty unit at or after rr_ptr, cyclically.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand_id    = '0;
    for (int unsigned i = 0; i < N_UNITS; i++) begin
      cand_id = ID_W'((32'(rr_ptr) + i) % N_UNITS);
      if (!pick_found && !unit_empty[cand_id]) begin
        pick_found = 1'b1;
        pick_id    = cand_id;
      end
    end
  end

  // Select the granted unit's output word.
  always_comb begin
    cur_word = '0;
    for (int unsigned i = 0; i < N_UNITS; i++) begin
      if (32'(unit_id) == i) begin
        cur_word = unit_dout[i*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and the one-hot read strobe during GRANT.
  always_comb begin
    state_nxt  = state;
    unit_rd_en = '0;
    case (state)
      IDLE:    if (dst_ready && pick_found) state_nxt = GRANT;
      GRANT: begin
        unit_rd_en[unit_id] = 1'b1;
        state_nxt           = HDR;
      end
      HDR:     state_nxt = XFER;
      XFER:    if (last_word) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: grant latch, RR pointer, header check, word forwarding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      unit_id    <= '0;
      cnt        <= '0;
      drop       <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      pkt_start  <= 1'b0;
      pkt_end    <= 1'b0;
      hdr_err    <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      pkt_start  <= 1'b0;
      pkt_end    <= 1'b0;
      case (state)
        IDLE: begin
          if (dst_ready && pick_found) unit_id <= pick_id;
        end
        GRANT: begin
          rr_ptr <= (32'(unit_id) == N_UNITS - 1) ? '0 : unit_id + 1'b1;
        end
        HDR: begin
          cnt  <= '0;
          drop <= (cur_word != '1);
          if (cur_word != '1) hdr_err <= 1'b1;
        end
        XFER: begin
          dout       <= cur_word;
          dout_valid <= ~drop;
          pkt_start  <= ~drop & (cnt == '0);
          pkt_end    <= ~drop & last_word;
          cnt        <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uob_output_arbiter.sv
// tb_uob_output_arbiter: directed bench for uob_output_arbiter with a
// behavioural model of the unit output buffers.
module tb_uob_output_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int NW = 40;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     unit_empty;
  logic [N*W-1:0]   unit_dout;
  logic [N-1:0]     unit_rd_en;
  logic             dst_ready;
  logic [W-1:0]     dout;
  logic             dout_valid;
  logic             pkt_start;
  logic             pkt_end;
  logic [1:0]       unit_id;
  logic             busy;
  logic             hdr_err;

  uob_output_arbiter #(
    .N_UNITS    (N),
    .UNIT_ID_MSB(1),
    .OUT_WIDTH  (W),
    .OUT_N_WORDS(NW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .unit_empty(unit_empty),
    .unit_dout (unit_dout),
    .unit_rd_en(unit_rd_en),
    .dst_ready (dst_ready),
    .dout      (dout),
    .dout_valid(dout_valid),
    .pkt_start (pkt_start),
    .pkt_end   (pkt_end),
    .unit_id   (unit_id),
    .busy      (busy),
    .hdr_err   (hdr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Unit buffer model: phase 1 = header, 2..NW+1 = data, NW+2 = trailing zero.
  logic [N-1:0] req;
  logic [W-1:0] hdr [N];
  int           phase [N] = '{default: 0};
  bit           start [N] = '{default: 0};

  function automatic logic [W-1:0] data_word(input int k, input int w);
    return W'(k * 64 + w);
  endfunction

  always_comb begin
    unit_empty = '0;
    unit_dout  = '0;
    for (int k = 0; k < N; k++) begin
      unit_empty[k] = ~req[k] | start[k] | (phase[k] != 0);
      if (phase[k] == 1)
        unit_dout[k*W +: W] = hdr[k];
      else if (phase[k] >= 2 && phase[k] <= NW + 1)
        unit_dout[k*W +: W] = data_word(k, phase[k] - 1);
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (!rst_n) begin
        phase[k] = 0;
        start[k] = 0;
      end else begin
        if (start[k]) begin
          phase[k] = 1;
          start[k] = 0;
        end else if (phase[k] > 0) begin
          phase[k] = (phase[k] >= NW + 2) ? 0 : phase[k] + 1;
        end
        if (unit_rd_en[k]) start[k] = 1;
      end
    end
  end

  // Monitor: log grants and forwarded words.
  typedef struct {
    logic [W-1:0] d;
    int           id;
    bit           s;
    bit           e;
    int           cyc;
  } word_t;

  int           gu [$];
  int           gc [$];
  logic [N-1:0] gv [$];
  word_t        wq [$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (unit_rd_en != '0) begin
        gv.push_back(unit_rd_en);
        gc.push_back(cyc);
        for (int k = N - 1; k >= 0; k--) begin
          if (unit_rd_en[k]) begin
            gu.push_back(k);
            break;
          end
        end
      end
      if (dout_valid) wq.push_back('{dout, int'(unit_id), pkt_start, pkt_end, cyc});
    end
  end

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    gu.delete();
    gc.delete();
    gv.delete();
    wq.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic wait_grants(input string tag, input int n, input int max);
    int k = 0;
    while (gu.size() < n && k < max) begin
      tick(1);
      k++;
    end
    check(tag, gu.size(), n);
  endtask

  task automatic wait_idle(input string tag, input int max);
    int k = 0;
    while (busy && k < max) begin
      tick(1);
      k++;
    end
    check(tag, {31'd0, busy}, 0);
  endtask

  task automatic check_packet(input string tag, input int first, input int k);
    int bad = 0;
    if (wq.size() < first + NW) begin
      bad = NW;
    end else begin
      for (int i = 0; i < NW; i++) begin
        word_t r = wq[first + i];
        if (r.d !== data_word(k, i + 1) || r.id != k || r.s != (i == 0) ||
            r.e != (i == NW - 1) || r.cyc != wq[first].cyc + i)
          bad++;
      end
    end
    check(tag, bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int x;
    int bs;
    rst_n     = 1'b0;
    req       = '0;
    dst_ready = 1'b0;
    for (int k = 0; k < N; k++) hdr[k] = 8'hFF;
    tick(2);
    check("rst_rd_en", {28'd0, unit_rd_en}, 0);
    check("rst_dout", {24'd0, dout}, 0);
    check("rst_flags", {27'd0, dout_valid, pkt_start, pkt_end, busy, hdr_err}, 0);
    check("rst_unit_id", {30'd0, unit_id}, 0);
    rst_n = 1'b1;
    tick(1);

    // single request from unit 2
    clear_logs();
    dst_ready = 1'b1;
    req       = 4'b0100;
    wait_grants("t1_grant", 1, 10);
    req = '0;
    wait_idle("t1_idle", 60);
    tick(2);
    check("t1_rd_en_val", (gv.size() > 0) ? {28'd0, gv[0]} : 32'hFFFF_FFFF, 32'h4);
    check("t1_rd_en_len", gv.size(), 1);
    check("t1_unit", (gu.size() > 0) ? gu[0] : -1, 2);
    check("t1_nwords", wq.size(), NW);
    check("t1_latency", (wq.size() > 0 && gc.size() > 0) ? wq[0].cyc - gc[0] : -1, 3);
    check_packet("t1_data", 0, 2);

    // all four requesting continuously
    do_reset();
    clear_logs();
    req = 4'hF;
    wait_grants("t2_grants", 5, 5 * 44 + 20);
    req = '0;
    check("t2_nwords", wq.size(), 4 * NW);
    for (int i = 0; i < 5; i++)
      check($sformatf("t2_order%0d", i), (gu.size() > i) ? gu[i] : -1, i % 4);
    for (int i = 1; i < 5; i++)
      check($sformatf("t2_space%0d", i), (gc.size() > i) ? gc[i] - gc[i-1] : -1, 44);
    for (int p = 0; p < 4; p++)
      check_packet($sformatf("t2_pkt%0d", p), p * NW, p);
    wait_idle("t2_idle", 60);

    // dst_ready low holds off arbitration
    clear_logs();
    dst_ready = 1'b0;
    req       = 4'b0010;
    bs        = 0;
    repeat (10) begin
      tick(1);
      if (busy) bs++;
    end
    check("t3_busy", bs, 0);
    check("t3_no_rd_en", gv.size(), 0);
    x         = cyc;
    dst_ready = 1'b1;
    wait_grants("t3_grant", 1, 10);
    check("t3_latency", (gc.size() > 0) ? gc[0] - x : -1, 1);
    check("t3_unit", (gu.size() > 0) ? gu[0] : -1, 1);
    req = '0;
    wait_idle("t3_idle", 60);

    // bad header on unit 2, then a good packet
    clear_logs();
    hdr[2] = 8'hFE;
    req    = 4'b0100;
    wait_grants("t4_grant", 1, 10);
    req = '0;
    wait_idle("t4_idle", 60);
    tick(2);
    check("t4_unit", (gu.size() > 0) ? gu[0] : -1, 2);
    check("t4_hdr_err", {31'd0, hdr_err}, 1);
    check("t4_dropped", wq.size(), 0);
    clear_logs();
    hdr[2] = 8'hFF;
    req    = 4'b0100;
    wait_grants("t4_grant2", 1, 10);
    req = '0;
    wait_idle("t4_idle2", 60);
    tick(2);
    check("t4_nwords2", wq.size(), NW);
    check_packet("t4_data2", 0, 2);
    check("t4_hdr_sticky", {31'd0, hdr_err}, 1);

    // pointer wrap: unit 3 last, then units 0 and 3 requesting
    clear_logs();
    req = 4'b1000;
    wait_grants("t6_grant3", 1, 10);
    check("t6_unit3", (gu.size() > 0) ? gu[0] : -1, 3);
    req = '0;
    wait_idle("t6_idle", 60);
    clear_logs();
    req = 4'b1001;
    wait_grants("t6_grant_wrap", 1, 10);
    check("t6_wrap_unit", (gu.size() > 0) ? gu[0] : -1, 0);
    req = '0;
    wait_idle("t6_idle2", 60);

    // reset in the middle of a transfer
    clear_logs();
    req = 4'b0010;
    wait_grants("t5_grant", 1, 10);
    req = '0;
    tick(12);
    check("t5_pre_valid", {31'd0, dout_valid}, 1);
    check("t5_pre_unit", {30'd0, unit_id}, 1);
    rst_n = 1'b0;
    #1;
    check("t5_rd_en", {28'd0, unit_rd_en}, 0);
    check("t5_dout", {24'd0, dout}, 0);
    check("t5_flags", {27'd0, dout_valid, pkt_start, pkt_end, busy, hdr_err}, 0);
    check("t5_unit_id", {30'd0, unit_id}, 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    clear_logs();
    req = 4'b1010;
    wait_grants("t5_grant_after", 1, 10);
    check("t5_unit_after", (gu.size() > 0) ? gu[0] : -1, 1);
    req = '0;
    wait_idle("t5_idle", 60);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
